mac_dot_sequencer: RTL and testbench
====================================

# mac_dot_sequencer

Controller that runs dot-product jobs on the MAC unit. It accepts a job length, clears the accumulator and streams operand pairs from a valid/ready source into the MAC one multiply at a time. After the last accumulation it returns the 40-bit accumulator value on a result handshake. It sits between the operand producer and `mac_top` and drives `start`, `clr_acc`, `A_in` and `B_in`, observing `ready_mac` and `Accumulator`.

## Interface

Parameters:
- DATA_WIDTH, 16: operand width; must match the MAC.
- ACC_WIDTH, 40: accumulator and result width.
- LEN_WIDTH, 8: job length field width; maximum job length is 2^LEN_WIDTH-1.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- job_start, in, 1: one-cycle request to begin a job; sampled only in IDLE.
- job_len, in, LEN_WIDTH: number of operand pairs, sampled with job_start.
- job_abort, in, 1: synchronous abort; returns the block to IDLE from any state.
- busy, out, 1: high in every state except IDLE.
- len_err, out, 1: one-cycle pulse when job_start arrives with job_len==0.
- op_valid, in, 1: operand pair valid.
- op_ready, out, 1: high only in WAIT_OP.
- op_a / op_b, in, DATA_WIDTH: signed operands.
- mac_start, out, 1: one-cycle start pulse to the MAC.
- mac_clr, out, 1: one-cycle accumulator clear.
- mac_a / mac_b, out, DATA_WIDTH: registered operands, stable from ISSUE until mac_ready.
- mac_ready, in, 1: multiply-done pulse; the MAC accumulates on the same edge.
- mac_acc, in, ACC_WIDTH: MAC accumulator value.
- res_valid, out, 1: result available; held until accepted.
- res_ready, in, 1: result consumer ready.
- res_data, out, ACC_WIDTH: captured dot product.

## Operation

- States: IDLE, CLEAR, WAIT_OP, ISSUE, WAIT_MAC, DRAIN, DONE.
- IDLE → CLEAR on job_start with job_len≠0:
  - latch len_q = job_len;
  - zero done_cnt.
- In IDLE, job_start with job_len==0 pulses len_err and the block stays in IDLE.
- CLEAR: mac_clr=1 for one cycle, then go to WAIT_OP.
- WAIT_OP: op_ready=1. On op_valid&&op_ready, register op_a/op_b into mac_a/mac_b and go to ISSUE.
- ISSUE: mac_start=1 for exactly one cycle, then go to WAIT_MAC.
- WAIT_MAC: on mac_ready, done_cnt increments.
  - If the new done_cnt==len_q, go to DRAIN.
  - Otherwise go to WAIT_OP.
- DRAIN: one cycle so mac_acc reflects the final accumulation; capture res_data=mac_acc and go to DONE.
- DONE: res_valid=1. On res_ready, go to IDLE and clear res_valid.
- mac_ready is ignored outside WAIT_MAC.
- job_start is ignored outside IDLE.
- job_abort has priority over all transitions:
  - next state is IDLE;
  - res_valid is cleared;
  - an in-flight multiply is abandoned without waiting;
  - the next job's CLEAR erases any late accumulation.
- Arithmetic: this block does none. res_data is mac_acc unmodified (signed, ACC_WIDTH). done_cnt is LEN_WIDTH wide and never wraps, because len_q ≤ 2^LEN_WIDTH-1.

## Timing

- Reset values: busy=0, len_err=0, op_ready=0, mac_start=0, mac_clr=0, mac_a=0, mac_b=0, res_valid=0, res_data=0; state IDLE.
- All outputs are registered or decoded purely from state. No combinational path from inputs to outputs except op_ready, which is state-only.
- Job latency from job_start to res_valid: 1 (CLEAR) + Σ per element (w_op + 1 ISSUE + L_mac) + 1 (DRAIN) + 1 cycle.
  - w_op ≥ 1 is the WAIT_OP dwell.
  - L_mac is the cycles from mac_start to mac_ready.
- Consecutive jobs: a new job_start is accepted in the first IDLE cycle after the res handshake.
- Reset asserted mid-job forces every output to its reset value immediately. No result is produced.
- Simultaneous job_abort and res_ready in DONE: abort wins; the result is dropped.

## Structure

- Shared package `mac_pkg`:
  - state enum `mac_seq_state_t`;
  - constants `MAC_ACC_WIDTH=40` and `MAC_DATA_WIDTH=16`, also used by the MAC blocks.
- No sub-module. The block is a single FSM plus len/done counters and operand/result registers.
- The next level wires it to `mac_top`.

## Test plan

- len=3, pairs (2,3),(-4,5),(7,7), MAC model with L_mac=17 → exactly 3 mac_start pulses, one mac_clr, res_data=35; res_valid held until res_ready.
- len=1, pair (-32768,-32768) → res_data=1073741824 (0x0040000000); busy falls the cycle after the res handshake.
- job_start with len=0 → len_err pulses for 1 cycle, busy stays 0, and no mac_start or mac_clr is issued.
- Abort during WAIT_MAC of element 2 of 4, then a new job of len=2 with pairs (1,1),(1,1) → new res_data=2 (the stale accumulation is cleared); a late mac_ready during IDLE is ignored.
- op_valid withheld for 10 cycles mid-job and res_ready held low for 5 cycles → op_ready stays high and mac_start stays 0 while waiting; res_data stays stable; no extra pulses.
- rst_n asserted in ISSUE → all outputs return to their reset values asynchronously; the next job after release produces the correct result.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: datapath widths and the dot-product sequencer state encoding.
package mac_pkg;

  localparam int MAC_ACC_WIDTH  = 40;
  localparam int MAC_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_WAIT_OP,
    SEQ_ISSUE,
    SEQ_WAIT_MAC,
    SEQ_DRAIN,
    SEQ_DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Runs one dot-product job on the MAC: clear, then one multiply per accepted operand pair, then
// hand back the accumulator. Operand source is stalled via op_ready; the result is held until res_ready.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_start,
  input  logic [LEN_WIDTH-1:0]  job_len,
  input  logic                  job_abort,
  output logic                  busy,
  output logic                  len_err,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  mac_start,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic                  mac_ready,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data
);

  mac_seq_state_t        state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  done_cnt_q;
  logic [LEN_WIDTH-1:0]  done_inc;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_b_q;
  logic [ACC_WIDTH-1:0]  res_data_q;
  logic                  len_err_q;
  logic                  job_accept;
  logic                  op_fire;

  assign job_accept = (state_q == SEQ_IDLE) && job_start && (job_len != '0);
  assign op_fire    = (state_q == SEQ_WAIT_OP) && op_valid;
  assign done_inc   = done_cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:     if (job_accept) state_d = SEQ_CLEAR;
      SEQ_CLEAR:    state_d = SEQ_WAIT_OP;
      SEQ_WAIT_OP:  if (op_valid) state_d = SEQ_ISSUE;
      SEQ_ISSUE:    state_d = SEQ_WAIT_MAC;
      SEQ_WAIT_MAC: if (mac_ready) state_d = (done_inc == len_q) ? SEQ_DRAIN : SEQ_WAIT_OP;
      SEQ_DRAIN:    state_d = SEQ_DONE;
      SEQ_DONE:     if (res_ready) state_d = SEQ_IDLE;
      default:      state_d = SEQ_IDLE;
    endcase
    // Abort overrides everything; an outstanding multiply is simply left behind.
    if (job_abort) state_d = SEQ_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      len_q      <= '0;
      done_cnt_q <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      res_data_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_err_q <= (state_q == SEQ_IDLE) && job_start && (job_len == '0) && !job_abort;
      if (job_accept) begin
        len_q      <= job_len;
        done_cnt_q <= '0;
      end else if ((state_q == SEQ_WAIT_MAC) && mac_ready) begin
        done_cnt_q <= done_inc;
      end
      if (op_fire) begin
        mac_a_q <= op_a;
        mac_b_q <= op_b;
      end
      // The last accumulation landed on the previous edge, so mac_acc is final here.
      if (state_q == SEQ_DRAIN) res_data_q <= mac_acc;
    end
  end

  assign busy      = (state_q != SEQ_IDLE);
  assign op_ready  = (state_q == SEQ_WAIT_OP);
  assign mac_start = (state_q == SEQ_ISSUE);
  assign mac_clr   = (state_q == SEQ_CLEAR);
  assign res_valid = (state_q == SEQ_DONE);
  assign len_err   = len_err_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural MAC and a sum-of-products reference.
module tb_mac_dot_sequencer;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_start, job_abort, op_valid, res_ready;
  logic [7:0]  job_len;
  logic        busy, len_err, op_ready, mac_start, mac_clr, mac_ready, res_valid;
  logic [15:0] op_a, op_b, mac_a, mac_b;
  logic [39:0] mac_acc, res_data;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.DATA_WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_len(job_len), .job_abort(job_abort),
    .busy(busy), .len_err(len_err), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
    .op_b(op_b), .mac_start(mac_start), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_ready(mac_ready), .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  // Behavioural MAC: latches operands on start, pulses ready mac_lat cycles later, accumulates on that edge.
  int                 mac_lat = 17;
  logic signed [39:0] acc_m;
  logic               mac_pend;
  int                 mac_cnt;
  longint             mac_prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_m <= '0; mac_ready <= 1'b0; mac_pend <= 1'b0; mac_cnt <= 0; mac_prod <= 0;
    end else begin
      mac_ready <= 1'b0;
      if (mac_clr) acc_m <= '0;
      else if (mac_ready) acc_m <= acc_m + 40'(mac_prod);
      if (mac_start) begin
        mac_prod <= longint'($signed(mac_a)) * longint'($signed(mac_b));
        mac_pend <= 1'b1;
        mac_cnt  <= mac_lat - 1;
      end else if (mac_pend) begin
        if (mac_cnt <= 0) begin mac_ready <= 1'b1; mac_pend <= 1'b0; end
        else mac_cnt <= mac_cnt - 1;
      end
    end
  end
  assign mac_acc = acc_m;

  int n_start = 0, n_clr = 0;
  always @(posedge clk) begin
    if (mac_start) n_start++;
    if (mac_clr) n_clr++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  int va[$], vb[$];

  function automatic logic [39:0] ref_dot();
    longint s = 0;
    for (int i = 0; i < va.size(); i++) s += longint'(va[i]) * longint'(vb[i]);
    return 40'(s);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill_random(input int n);
    va.delete(); vb.delete();
    for (int i = 0; i < n; i++) begin va.push_back(rnd16()); vb.push_back(rnd16()); end
  endtask

  task automatic start_job(input int n);
    @(negedge clk); job_start = 1'b1; job_len = 8'(n);
    @(negedge clk); job_start = 1'b0; job_len = '0;
  endtask

  task automatic send_pair(input int a, input int b, input int gap, input string tag);
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_op_ready_timeout"}, 64'(op_ready), 64'd1);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk({tag, "_stall_op_ready"}, 64'(op_ready), 64'd1);
      chk({tag, "_stall_no_start"}, 64'(mac_start), 64'd0);
    end
    op_valid = 1'b1; op_a = 16'(a); op_b = 16'(b);
    @(posedge clk); #1 op_valid = 1'b0;
  endtask

  task automatic run_job(input int gap_idx, input int gap, input int hold, input string tag);
    logic [39:0] exp = ref_dot();
    int s_start = n_start, s_clr = n_clr;
    bit ok = 0;
    start_job(va.size());
    chk({tag, "_busy_clear"}, 64'(busy), 64'd1);
    chk({tag, "_clr_pulse"}, 64'(mac_clr), 64'd1);
    for (int i = 0; i < va.size(); i++) send_pair(va[i], vb[i], (i == gap_idx) ? gap : 0, tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    chk({tag, "_res_valid"}, 64'(ok), 64'd1);
    chk({tag, "_res_data"}, 64'(res_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_hold_data"}, 64'(res_data), 64'(exp));
    end
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_valid_after"}, 64'(res_valid), 64'd0);
    chk({tag, "_n_start"}, 64'(n_start - s_start), 64'(va.size()));
    chk({tag, "_n_clr"}, 64'(n_clr - s_clr), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_len_err"}, 64'(len_err), 64'd0);
    chk({tag, "_op_ready"}, 64'(op_ready), 64'd0);
    chk({tag, "_mac_start"}, 64'(mac_start), 64'd0);
    chk({tag, "_mac_clr"}, 64'(mac_clr), 64'd0);
    chk({tag, "_mac_a"}, 64'(mac_a), 64'd0);
    chk({tag, "_mac_b"}, 64'(mac_b), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"}, 64'(res_data), 64'd0);
  endtask

  initial begin
    int s_start, s_clr;
    bit ok;
    rst_n = 1'b0; job_start = 1'b0; job_len = '0; job_abort = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed: small mixed-sign job with slow MAC and delayed result consumer.
    mac_lat = 17;
    va = '{2, -4, 7}; vb = '{3, 5, 7};
    chk("ref_35", 64'(ref_dot()), 64'd35);
    run_job(-1, 0, 3, "len3");

    // Most-negative operands squared.
    va = '{-32768}; vb = '{-32768};
    run_job(-1, 0, 0, "len1_min");

    // Zero-length request.
    s_start = n_start; s_clr = n_clr;
    start_job(0);
    chk("len0_err_pulse", 64'(len_err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("len0_err_clear", 64'(len_err), 64'd0);
    chk("len0_busy2", 64'(busy), 64'd0);
    chk("len0_no_start", 64'(n_start - s_start), 64'd0);
    chk("len0_no_clr", 64'(n_clr - s_clr), 64'd0);

    // Abort while the second of four multiplies is in flight.
    fill_random(4);
    s_start = n_start;
    start_job(4);
    send_pair(va[0], vb[0], 0, "abort");
    send_pair(va[1], vb[1], 0, "abort");
    @(negedge clk); @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk); job_abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_op_ready", 64'(op_ready), 64'd0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mac_pend) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("abort_late_ready_seen", 64'(ok), 64'd1);
    @(negedge clk);
    chk("abort_idle_after_late_ready", 64'(busy), 64'd0);
    chk("abort_start_count", 64'(n_start - s_start), 64'd2);
    va = '{1, 1}; vb = '{1, 1};
    run_job(-1, 0, 0, "post_abort");

    // Operand stall mid-job and a slow result consumer.
    mac_lat = 3;
    fill_random(3);
    run_job(1, 10, 5, "stall");

    // Reset asserted while the sequencer is in ISSUE.
    va = '{5}; vb = '{6};
    start_job(2);
    send_pair(5, 6, 0, "rst_mid");
    chk("rst_mid_in_issue", 64'(mac_start), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random(3);
    run_job(-1, 0, 1, "after_rst");

    // Randomized jobs against the reference.
    for (int r = 0; r < 8; r++) begin
      mac_lat = int'($urandom_range(1, 6));
      fill_random(int'($urandom_range(1, 9)));
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
